// File: rtl/int_add_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external integer adder.
// Each operation runs IDLE -> ISSUE -> OUT; the result is held in OUT until downstream accepts it.
module int_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_OPC  = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              I_Req,
    input  logic [NUM_REQ*WIDTH_OPC-1:0]    I_Opcode,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]   I_SrcA,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]   I_SrcB,
    output logic [NUM_REQ-1:0]              O_Ack,
    output logic                            O_En,
    output logic [WIDTH_OPC-1:0]            O_Opcode,
    output logic [WIDTH_DATA-1:0]           O_OperandA,
    output logic [WIDTH_DATA-1:0]           O_OperandB,
    input  logic                            I_AddValid,
    input  logic [WIDTH_DATA-1:0]           I_AddData,
    input  logic                            I_AddCond,
    output logic                            O_Valid,
    output logic [WIDTH_DATA-1:0]           O_Data,
    output logic                            O_Cond,
    output logic [$clog2(NUM_REQ)-1:0]      O_Id,
    input  logic                            I_Nack,
    output logic                            O_Err
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] sel_idx;
    logic [ID_W-1:0] cand;
    logic            sel_found;

    // (base + offset) mod NUM_REQ for offsets below NUM_REQ, valid for non-power-of-two counts
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[ID_W-1:0];
    endfunction

    // Scan from the farthest offset down so the request closest to ptr wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_idx(ptr, k);
            if (I_Req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_found) state_next = ISSUE;
            ISSUE:   state_next = I_AddValid ? OUT : IDLE;
            OUT:     if (!I_Nack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign O_En = (state == ISSUE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            grant_idx  <= '0;
            O_Ack      <= '0;
            O_Opcode   <= '0;
            O_OperandA <= '0;
            O_OperandB <= '0;
            O_Valid    <= 1'b0;
            O_Data     <= '0;
            O_Cond     <= 1'b0;
            O_Id       <= '0;
            O_Err      <= 1'b0;
        end else begin
            O_Ack <= '0;
            if (state == IDLE && sel_found) begin
                O_Ack[sel_idx] <= 1'b1;
                grant_idx      <= sel_idx;
                ptr            <= wrap_idx(sel_idx, 1);
                O_Opcode       <= I_Opcode[sel_idx*WIDTH_OPC +: WIDTH_OPC];
                O_OperandA     <= I_SrcA[sel_idx*WIDTH_DATA +: WIDTH_DATA];
                O_OperandB     <= I_SrcB[sel_idx*WIDTH_DATA +: WIDTH_DATA];
            end
            // An adder that fails to answer in its issue cycle drops the op and flags it
            if (state == ISSUE) begin
                if (I_AddValid) begin
                    O_Valid <= 1'b1;
                    O_Data  <= I_AddData;
                    O_Cond  <= I_AddCond;
                    O_Id    <= grant_idx;
                end else begin
                    O_Err <= 1'b1;
                end
            end
            if (state == OUT && !I_Nack) O_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_add_arbiter.sv
// Bench for int_add_arbiter: a small adder model sits behind the adder ports; expected
// grants and results are queued by the stimulus and checked by an independent monitor.
module tb_int_add_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        cond;
        logic [1:0]  id;
    } res_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req;
    logic [23:0]  opc;
    logic [127:0] src_a;
    logic [127:0] src_b;
    logic [3:0]   ack;
    logic         en;
    logic [5:0]   add_opc;
    logic [31:0]  opa;
    logic [31:0]  opb;
    logic         add_valid;
    logic [31:0]  sum;
    logic         add_cond;
    logic         add_kill;
    logic         valid;
    logic [31:0]  data;
    logic         cond;
    logic [1:0]   id;
    logic         nack;
    logic         err;

    int   checks = 0;
    int   errors = 0;
    int   grant_q[$];
    res_t res_q[$];
    int   g;
    res_t r;

    int_add_arbiter #(.NUM_REQ(4), .WIDTH_DATA(32), .WIDTH_OPC(6)) dut (
        .clock(clock), .reset(reset),
        .I_Req(req), .I_Opcode(opc), .I_SrcA(src_a), .I_SrcB(src_b),
        .O_Ack(ack), .O_En(en), .O_Opcode(add_opc), .O_OperandA(opa), .O_OperandB(opb),
        .I_AddValid(add_valid), .I_AddData(sum), .I_AddCond(add_cond),
        .O_Valid(valid), .O_Data(data), .O_Cond(cond), .O_Id(id),
        .I_Nack(nack), .O_Err(err)
    );

    always #5 clock = ~clock;

    // Adder behind the ports: bit0 selects subtract, cond flags a zero result
    always_comb begin
        sum       = add_opc[0] ? (opa - opb) : (opa + opb);
        add_cond  = (sum == 32'd0);
        add_valid = en & ~add_kill;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requesters drop their request once they see their ack
    task automatic tick();
        @(posedge clock);
        #1;
        req = req & ~ack;
    endtask

    task automatic set_op(input int i, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        opc[i*6 +: 6]    = o;
        src_a[i*32 +: 32] = a;
        src_b[i*32 +: 32] = b;
    endtask

    task automatic expect_op(input int i, input logic [31:0] d, input logic c);
        res_t e;
        e.data = d;
        e.cond = c;
        e.id   = 2'(i);
        grant_q.push_back(i);
        res_q.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((grant_q.size() != 0 || res_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n >= 60), 32'd0);
        tick();
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (ack != 4'd0) begin
                if (grant_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
                else begin
                    g = grant_q.pop_front();
                    chk("grant_order", 32'(ack), 32'(1) << g);
                end
            end
            if (valid && !nack) begin
                if (res_q.size() == 0) chk("unexpected_valid", 32'(valid), 32'd0);
                else begin
                    r = res_q.pop_front();
                    chk("result_data", data, r.data);
                    chk("result_cond", 32'(cond), 32'(r.cond));
                    chk("result_id", 32'(id), 32'(r.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0; opc = '0; src_a = '0; src_b = '0; nack = 1'b0; add_kill = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", data, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;

        // All four request at once: strict rotation from ptr 0
        set_op(0, 6'h00, 32'd1, 32'd2);
        set_op(1, 6'h00, 32'd10, 32'd20);
        set_op(2, 6'h00, 32'hFFFF_FFFF, 32'd1);
        set_op(3, 6'h01, 32'd100, 32'd1);
        expect_op(0, 32'd3, 1'b0);
        expect_op(1, 32'd30, 1'b0);
        expect_op(2, 32'd0, 1'b1);
        expect_op(3, 32'd99, 1'b0);
        req = 4'b1111;
        wait_done();

        set_op(0, 6'h00, 32'd5, 32'd3);
        expect_op(0, 32'd8, 1'b0);
        req = 4'b0001;
        wait_done();

        // Single request with ptr at 1 must wrap to 0; ack at cycle 1, result at cycle 2
        expect_op(0, 32'd8, 1'b0);
        req = 4'b0001;
        tick();
        chk("lat_ack", 32'(ack), 32'd1);
        chk("lat_en", 32'(en), 32'd1);
        chk("lat_opa", opa, 32'd5);
        chk("lat_opb", opb, 32'd3);
        tick();
        chk("lat_valid", 32'(valid), 32'd1);
        chk("lat_data", data, 32'd8);
        chk("lat_en_off", 32'(en), 32'd0);
        wait_done();

        set_op(2, 6'h01, 32'd3, 32'd5);
        expect_op(2, 32'hFFFF_FFFE, 1'b0);
        req = 4'b0100;
        wait_done();

        // Stall for three cycles in OUT
        set_op(1, 6'h01, 32'd7, 32'd7);
        expect_op(1, 32'd0, 1'b1);
        nack = 1'b1;
        req  = 4'b0010;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) nack = 1'b0;
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_data", data, 32'd0);
            chk("stall_ack", 32'(ack), 32'd0);
            if (i < 3) tick();
        end
        tick();
        chk("stall_release", 32'(valid), 32'd0);
        wait_done();

        // Adder refuses to answer: sticky error, no result
        add_kill = 1'b1;
        grant_q.push_back(3);
        req = 4'b1000;
        tick();
        tick();
        chk("err_set", 32'(err), 32'd1);
        chk("err_no_valid", 32'(valid), 32'd0);
        add_kill = 1'b0;
        tick();
        chk("err_no_valid2", 32'(valid), 32'd0);
        set_op(0, 6'h00, 32'd40, 32'd2);
        expect_op(0, 32'd42, 1'b0);
        req = 4'b0001;
        wait_done();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of an issue cycle
        set_op(1, 6'h00, 32'd11, 32'd22);
        req = 4'b0010;
        tick();
        chk("pre_rst_ack", 32'(ack), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_cond", 32'(cond), 32'd0);
        chk("mid_rst_id", 32'(id), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_opc", 32'(add_opc), 32'd0);
        chk("mid_rst_opa", opa, 32'd0);
        chk("mid_rst_opb", opb, 32'd0);
        req = '0;
        @(posedge clock);
        #2 reset = 1'b1;
        tick();
        chk("no_replay_ack", 32'(ack), 32'd0);
        chk("no_replay_valid", 32'(valid), 32'd0);
        expect_op(0, 32'd42, 1'b0);
        expect_op(3, 32'd99, 1'b0);
        req = 4'b1001;
        wait_done();

        chk("final_grant_q", 32'(grant_q.size()), 32'd0);
        chk("final_res_q", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_add_arbiter.md
INT_ADD_ARBITER -- requirements
Module: int_add_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one integer adder; legal range 2..8.
REQ-002 SHALL have parameter WIDTH_DATA, default 32: operand and result width.
REQ-003 SHALL have parameter WIDTH_OPC, default 6: adder opcode width (bit0 sub, bit1 signed, bit2 saturate, bit4/5 condition output).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 I_Req  in  NUM_REQ  per-requester request; held until the matching O_Ack.
REQ-008 I_Opcode  in  NUM_REQ*WIDTH_OPC  per-requester opcode, slice i = requester i.
REQ-009 I_SrcA / I_SrcB  in  NUM_REQ*WIDTH_DATA each  per-requester operands.
REQ-010 O_Ack  out  NUM_REQ  one-hot grant pulse.
REQ-011 O_En  out  1  adder enable; O_Opcode out WIDTH_OPC; O_OperandA / O_OperandB out WIDTH_DATA, driven to the adder.
REQ-012 I_AddValid in 1, I_AddData in WIDTH_DATA, I_AddCond in 1: combinational adder result.
REQ-013 O_Valid out 1, O_Data out WIDTH_DATA, O_Cond out 1, O_Id out $clog2(NUM_REQ): registered result and owner.
REQ-014 I_Nack  in  1  downstream stall; O_Err  out  1  sticky adder-invalid flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, OUT; reset state IDLE.
REQ-016 IDLE: if any I_Req, SHALL select the first set request at or after Ptr (wrapping modulo NUM_REQ), latch its index, opcode and operands, and go to ISSUE; with no request, SHALL remain in IDLE.
REQ-017 Requests arriving while not in IDLE SHALL NOT be sampled.
REQ-018 Ptr SHALL update to (granted index + 1) mod NUM_REQ on every grant; NUM_REQ-1 wraps to 0.
REQ-019 O_Ack[granted] SHALL be a registered one-cycle pulse, high exactly during the ISSUE cycle; all other bits SHALL be 0.
REQ-020 ISSUE: O_En = 1, with O_Opcode/O_OperandA/O_OperandB driven from the latched registers; O_En SHALL be 0 in every other state.
REQ-021 ISSUE with I_AddValid = 1: SHALL capture I_AddData, I_AddCond and the index into O_Data/O_Cond/O_Id, set O_Valid, and go to OUT.
REQ-022 ISSUE with I_AddValid = 0: SHALL set O_Err (sticky until reset), produce no output, and return to IDLE.
REQ-023 OUT: O_Valid = 1 and outputs SHALL stay stable while I_Nack = 1; on the first cycle with I_Nack = 0, the transfer completes, O_Valid clears on the next edge, and the FSM returns to IDLE.
REQ-024 Latency from request sampled in IDLE to O_Valid SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-025 Operand, result and opcode widths SHALL pass unmodified; no arithmetic SHALL be performed in this block.

Reset
REQ-026 Asserting reset SHALL immediately force the following, in any state including mid-ISSUE or mid-OUT: state IDLE, Ptr 0, O_Ack 0, O_En 0, O_Valid 0, O_Data 0, O_Cond 0, O_Id 0, O_Err 0, O_Opcode/O_OperandA/O_OperandB 0.
REQ-027 No grant or result in progress at reset SHALL be retained or replayed after reset release.

Verification
REQ-028 Bench with an adder behind the ports: only I_Req[0], A=5, B=3, opcode 0x00 -> O_Ack[0] in cycle 1, O_Valid in cycle 2 with O_Data = 8 and O_Id = 0.
REQ-029 I_Req = 4'b1111 held, each requester dropping its request after its Ack -> grant order 0,1,2,3; then requester 0 re-requests -> grant 0.
REQ-030 Requester 2, opcode 0x01, A=3, B=5 -> O_Data = 0xFFFFFFFE, O_Id = 2.
REQ-031 I_Nack high for 3 cycles in OUT -> O_Valid/O_Data stable for 4 cycles, no O_Ack meanwhile, then IDLE.
REQ-032 Reset asserted during ISSUE -> all outputs 0 asynchronously; after release, I_Req = 4'b1001 -> grant 0.
REQ-033 I_AddValid forced 0 in ISSUE -> O_Err = 1, O_Valid stays 0, FSM returns to IDLE, O_Err held until reset.
